ir_tx_packet_sm: RTL
====================

# ir_tx_packet_sm

- Packet state machine behind the top-level `IR_LED` output.
- Sends one remote-control packet per trigger. The packet is a sequence of carrier-modulated bursts separated by gaps: start, car-select, then one burst each for right, left, backward and forward.
- Carrier frequency and burst lengths come from one of four car profiles.
- Sits between the bus-mapped command register (upstream, supplies `COMMAND`/`CAR_SEL`/`SEND`) and the `IR_LED` pin (downstream, checked by the top-level stimulus bench).

## Interface

Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
  - Carrier period in cycles P = (CLK_HZ + f/2) / f, integer.
- `PKT_HZ`, 10, packet rate. Used only when `IR_TX_AUTO_RESEND_EN` is defined.

Ports:
- `CLK`  in  1  system clock. One clock domain; the only clock.
- `RESET`  in  1  asynchronous, active-low reset.
- `SEND`  in  1  one-cycle packet request.
- `COMMAND`  in  4  {forward, backward, left, right}, bit 3 = forward.
- `CAR_SEL`  in  2  profile select: 0 blue, 1 yellow, 2 green, 3 red.
- `IR_LED`  out  1  modulated output. Registered.
- `BUSY`  out  1  high while a packet is in progress. Registered.

## Operation

Profiles (f; start, gap, carsel, assert, deassert, all in carrier periods):
- blue: 36 kHz; 191, 25, 47, 47, 22
- yellow: 40 kHz; 88, 40, 22, 44, 22
- green: 37.5 kHz; 88, 40, 44, 44, 22
- red: 36 kHz; 192, 24, 24, 48, 24

State sequence:
- IDLE → START → GAP → CARSEL → GAP → RIGHT → GAP → LEFT → GAP → BACK → GAP → FWD → IDLE.
- The GAP state tracks which burst follows it.

Burst states:
- The carrier runs: `IR_LED` is high for floor(P/2) cycles, then low for P − floor(P/2) cycles, repeated.
- The burst length in periods is the profile value.
- Command bursts use `assert` when their `COMMAND` bit is 1, `deassert` when it is 0.

GAP:
- `IR_LED` is held low for gap × P cycles.

Counters:
- A cycle counter within the carrier period, 12 bits.
- A period counter within the state, 8 bits.
- Both clear on every state transition, so each burst starts in the high phase.

Latching and handshake:
- `COMMAND` and `CAR_SEL` are latched when `SEND` is accepted in IDLE.
- Input changes mid-packet have no effect on the packet in progress.
- `SEND` while `BUSY` = 1 is dropped. It is not queued.

Reset:
- `RESET` low forces IDLE, clears both counters, and drives `IR_LED` = 0 and `BUSY` = 0 asynchronously.
- This applies at any point, including mid-burst.

## Timing

- Outputs at reset: `IR_LED` 0, `BUSY` 0.
- `SEND` sampled high in IDLE at edge k: `BUSY` and `IR_LED` are both 1 from edge k+1.
- Last cycle of the FWD burst:
  - `IR_LED` low-phase ends at edge m.
  - IDLE, `BUSY` = 0 from edge m+1.
  - A new `SEND` at edge m+1 is accepted.
- `SEND` coincident with the final cycle of a packet (`BUSY` still 1) is dropped.
- Packet length in cycles = P × (start + carsel + 4·gap + Σ command bursts) + P × gap between bursts. That is 5 gaps in total, with no gap after FWD.
  - Blue, all commands 0: P = 2778; (191 + 5·25 + 47 + 4·22) × 2778 = 451 × 2778 = 1 252 878 cycles.
- `RESET` deasserts asynchronously. The first `SEND` is sampled at the first rising edge with `RESET` high.

## Configuration

`IR_TX_AUTO_RESEND_EN`:
- Defined:
  - An internal counter raises a request every CLK_HZ/PKT_HZ cycles (default 10 000 000).
  - The `SEND` port is ignored.
  - `COMMAND` and `CAR_SEL` are latched at each internal request.
  - A request that falls while `BUSY` is dropped.
  - The counter clears on reset; the first request arrives CLK_HZ/PKT_HZ cycles after reset release.
- Undefined: packets are sent only on `SEND`; there is no internal timer.

## Test plan

- Reset mid-burst: assert `RESET` low during START → `IR_LED` = 0 and `BUSY` = 0 within the same cycle; after release, IDLE with no output until `SEND`.
- Blue, `COMMAND` = 0000, `SEND` pulse → first high phase 1389 cycles, then low 1389; START lasts 191 × 2778 = 530 598 cycles; GAP is low for 69 450 cycles; `BUSY` spans 1 252 878 cycles.
- Yellow, `COMMAND` = 1010 (forward, left) → P = 2500; RIGHT 22 periods, LEFT 44, BACK 22, FWD 44; CARSEL 22 periods (55 000 cycles).
- Green → high phase 1333 cycles, low 1334; START 88 × 2667 cycles.
- `SEND` pulsed again mid-packet, and `COMMAND` changed mid-packet → no restart and no effect on bursts; a new `SEND` one cycle after `BUSY` falls starts a packet on the next edge.
- With `IR_TX_AUTO_RESEND_EN` defined and `CLK_HZ` = 3 600 000 → red P = 100; a packet begins 360 000 cycles after reset release and repeats every 360 000 cycles; `SEND` has no effect.

Source files
------------

// File: rtl/ir_tx_packet_sm.sv
// IR remote packet sequencer: start, car-select and four command bursts on a per-car carrier.
// Define IR_TX_AUTO_RESEND_EN to send packets from an internal PKT_HZ timer instead of SEND.
module ir_tx_packet_sm #(
    parameter int CLK_HZ = 100_000_000,
    parameter int PKT_HZ = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND,
    input  logic [3:0] COMMAND,
    input  logic [1:0] CAR_SEL,
    output logic       IR_LED,
    output logic       BUSY
);

    localparam int P_BLUE   = (CLK_HZ + 18_000) / 36_000;
    localparam int P_YELLOW = (CLK_HZ + 20_000) / 40_000;
    localparam int P_GREEN  = (CLK_HZ + 18_750) / 37_500;
    localparam int P_RED    = (CLK_HZ + 18_000) / 36_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_CARSEL,
        S_RIGHT,
        S_LEFT,
        S_BACK,
        S_FWD
    } state_t;

    state_t      r_state;
    state_t      r_after_gap;
    logic [11:0] r_cycle;
    logic [7:0]  r_period;
    logic [3:0]  r_cmd;
    logic [1:0]  r_car;
    logic        r_led;
    logic        r_busy;

    logic [11:0] w_p;
    logic [11:0] w_half;
    logic [7:0]  w_start;
    logic [7:0]  w_gap;
    logic [7:0]  w_carsel;
    logic [7:0]  w_assert;
    logic [7:0]  w_deassert;
    logic [7:0]  w_len;
    logic        w_is_burst;
    logic        w_last_cycle;
    logic        w_last_period;
    state_t      w_next_state;
    state_t      w_next_after;
    logic        w_next_is_burst;
    logic        w_req;

`ifdef IR_TX_AUTO_RESEND_EN
    localparam int AUTO_CYCLES = CLK_HZ / PKT_HZ;
    localparam int TW          = $clog2(AUTO_CYCLES + 1);

    logic [TW-1:0] r_timer;
    logic          w_unused_send;

    assign w_unused_send = SEND;
    assign w_req         = (r_timer == TW'(AUTO_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_timer <= '0;
        end else if (w_req) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    logic w_unused_pkt;

    assign w_unused_pkt = (PKT_HZ != 0);
    assign w_req        = SEND;
`endif

    always_comb begin
        w_p        = 12'(P_BLUE);
        w_start    = 8'd191;
        w_gap      = 8'd25;
        w_carsel   = 8'd47;
        w_assert   = 8'd47;
        w_deassert = 8'd22;
        case (r_car)
            2'd1: begin
                w_p        = 12'(P_YELLOW);
                w_start    = 8'd88;
                w_gap      = 8'd40;
                w_carsel   = 8'd22;
                w_assert   = 8'd44;
                w_deassert = 8'd22;
            end
            2'd2: begin
                w_p        = 12'(P_GREEN);
                w_start    = 8'd88;
                w_gap      = 8'd40;
                w_carsel   = 8'd44;
                w_assert   = 8'd44;
                w_deassert = 8'd22;
            end
            2'd3: begin
                w_p        = 12'(P_RED);
                w_start    = 8'd192;
                w_gap      = 8'd24;
                w_carsel   = 8'd24;
                w_assert   = 8'd48;
                w_deassert = 8'd24;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_len        = 8'd1;
        w_next_state = S_IDLE;
        w_next_after = r_after_gap;
        case (r_state)
            S_START: begin
                w_len        = w_start;
                w_next_state = S_GAP;
                w_next_after = S_CARSEL;
            end
            S_GAP: begin
                w_len        = w_gap;
                w_next_state = r_after_gap;
            end
            S_CARSEL: begin
                w_len        = w_carsel;
                w_next_state = S_GAP;
                w_next_after = S_RIGHT;
            end
            S_RIGHT: begin
                w_len        = r_cmd[0] ? w_assert : w_deassert;
                w_next_state = S_GAP;
                w_next_after = S_LEFT;
            end
            S_LEFT: begin
                w_len        = r_cmd[1] ? w_assert : w_deassert;
                w_next_state = S_GAP;
                w_next_after = S_BACK;
            end
            S_BACK: begin
                w_len        = r_cmd[2] ? w_assert : w_deassert;
                w_next_state = S_GAP;
                w_next_after = S_FWD;
            end
            S_FWD: begin
                w_len        = r_cmd[3] ? w_assert : w_deassert;
                w_next_state = S_IDLE;
            end
            default: ;
        endcase
    end

    assign w_half          = w_p >> 1;
    assign w_is_burst      = (r_state != S_IDLE) && (r_state != S_GAP);
    assign w_next_is_burst = (w_next_state != S_IDLE) && (w_next_state != S_GAP);
    assign w_last_cycle    = (r_cycle == w_p - 12'd1);
    assign w_last_period   = (r_period == w_len - 8'd1);

    // IR_LED is registered as the value for the cycle about to start, so every burst opens high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_after_gap <= S_CARSEL;
            r_cycle     <= '0;
            r_period    <= '0;
            r_cmd       <= '0;
            r_car       <= '0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_req) begin
                r_cmd    <= COMMAND;
                r_car    <= CAR_SEL;
                r_state  <= S_START;
                r_cycle  <= '0;
                r_period <= '0;
                r_led    <= 1'b1;
                r_busy   <= 1'b1;
            end
        end else if (!w_last_cycle) begin
            r_cycle <= r_cycle + 12'd1;
            r_led   <= w_is_burst && ((r_cycle + 12'd1) < w_half);
        end else if (!w_last_period) begin
            r_cycle  <= '0;
            r_period <= r_period + 8'd1;
            r_led    <= w_is_burst;
        end else begin
            r_cycle     <= '0;
            r_period    <= '0;
            r_state     <= w_next_state;
            r_after_gap <= w_next_after;
            r_led       <= w_next_is_burst;
            r_busy      <= (w_next_state != S_IDLE);
        end
    end

    assign IR_LED = r_led;
    assign BUSY   = r_busy;

endmodule
